// File: rtl/flasher_pkg.sv
// Shared definitions for the Bound Flasher back end.
// Contents:
//   state_e        - 3-bit state encodings produced by the next-state logic
//   LED_NUM, CNT_W - lamp count and width of the lit-lamp counter
//   is_ramp_up     - state grows the lit-lamp count by one per tick
//   is_ramp_down   - state shrinks the lit-lamp count by one per tick
//   lamp_mask      - thermometer code with the lowest n lamps lit
package flasher_pkg;

    localparam int unsigned LED_NUM = 16;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [2:0] {
        ST_INITIAL  = 3'd0,
        ST_0_TO_15  = 3'd1,
        ST_15_TO_5  = 3'd2,
        ST_5_TO_10  = 3'd3,
        ST_10_TO_0  = 3'd4,
        ST_0_TO_5   = 3'd5,
        ST_5_TO_0   = 3'd6
    } state_e;

    function automatic logic is_ramp_up(input logic [2:0] state);
        return (state == ST_0_TO_15) || (state == ST_5_TO_10) || (state == ST_0_TO_5);
    endfunction

    function automatic logic is_ramp_down(input logic [2:0] state);
        return (state == ST_15_TO_5) || (state == ST_10_TO_0) || (state == ST_5_TO_0);
    endfunction

    // Bit i is lit when i < n, so n = LED_NUM lights every lamp.
    function automatic logic [LED_NUM-1:0] lamp_mask(input logic [CNT_W-1:0] n);
        logic [LED_NUM-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LED_NUM; i++) begin
            m[i] = (i < 32'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/flasher_output_stage_if.sv
// Bus between the Bound Flasher next-state logic and its output stage.
// Signals:
//   flk_in - raw flick button (asynchronous to clk)
//   nxt_st - next state from the next-state logic
//   cur_st - registered current state
//   count  - number of lamps lit, 0..16
//   flk    - conditioned flick flag
//   tick   - one-clk step strobe
//   lamps  - lamp drive, bit i = LED i
// Modports:
//   master - next-state logic side (drives flk_in/nxt_st)
//   slave  - output stage side (drives the registered outputs)
interface flasher_output_stage_if;
    import flasher_pkg::*;

    logic                 flk_in;
    logic [2:0]           nxt_st;
    logic [2:0]           cur_st;
    logic [CNT_W-1:0]     count;
    logic                 flk;
    logic                 tick;
    logic [LED_NUM-1:0]   lamps;

    modport master (
        output flk_in,
        output nxt_st,
        input  cur_st,
        input  count,
        input  flk,
        input  tick,
        input  lamps
    );

    modport slave (
        input  flk_in,
        input  nxt_st,
        output cur_st,
        output count,
        output flk,
        output tick,
        output lamps
    );

endinterface

// File: rtl/flasher_output_stage_tick_gen.sv
// Free-running clock divider producing a one-clk step strobe.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - high for one clk every DIV_CNT clks; first strobe is DIV_CNT
//           clks after reset release
// Parameters:
//   DIV_CNT - clks per strobe, minimum 2
module tick_gen #(
    parameter int unsigned DIV_CNT = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(DIV_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Decoded straight from the divider so it is low during reset.
    assign tick = (div == DIV_LAST);

endmodule

// File: rtl/flasher_output_stage.sv
// Sequential back end of the Bound Flasher.
// Registers the next-state code once per step tick, keeps the lit-lamp
// count (saturating 0..LED_NUM), drives the thermometer lamp output and
// turns the raw flick button into a flag held until the next tick.
// Ports:
//   clk   - system clock, all logic rising-edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of flasher_output_stage_if
//           (flk_in, nxt_st in; cur_st, count, flk, tick, lamps out)
// Parameters:
//   DIV_CNT - clks per step tick (minimum 2)
//   LED_NUM - number of lamps; count saturates at this value
module flasher_output_stage
    import flasher_pkg::*;
#(
    parameter int unsigned DIV_CNT = 25_000_000,
    parameter int unsigned LED_NUM = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flasher_output_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LED_NUM);

    logic              tick;
    logic              sync1;
    logic              sync2;
    logic              sync_prev;
    logic              flk_edge;
    logic              flk;
    logic [2:0]        cur_st;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [15:0]       lamps;

    tick_gen #(
        .DIV_CNT(DIV_CNT)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Two-flop synchronizer plus a history flop for rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= bus.flk_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign flk_edge = sync2 & ~sync_prev;

    // The flag is consumed by the tick cycle; an edge arriving in that same
    // cycle keeps it set for the following window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flk <= 1'b0;
        end else if (flk_edge) begin
            flk <= 1'b1;
        end else if (tick) begin
            flk <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= ST_INITIAL;
        end else if (tick) begin
            cur_st <= bus.nxt_st;
        end
    end

    // Direction comes from the state being left, not the one being loaded.
    always_comb begin
        count_next = count;
        if (tick) begin
            if (is_ramp_up(cur_st)) begin
                count_next = (count >= CNT_MAX) ? CNT_MAX : count + CNT_W'(1);
            end else if (is_ramp_down(cur_st)) begin
                count_next = (count == '0) ? '0 : count - CNT_W'(1);
            end else begin
                count_next = '0;
            end
        end
    end

    // Lamps are registered from count_next so they track count cycle-exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            lamps <= '0;
        end else begin
            count <= count_next;
            lamps <= lamp_mask(count_next);
        end
    end

    assign bus.cur_st = cur_st;
    assign bus.count  = count;
    assign bus.flk    = flk;
    assign bus.tick   = tick;
    assign bus.lamps  = lamps;

endmodule
